// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared types for the ACE request sequencer
// Holds the request type encoding, sequencer state encoding and the packed
// FIFO entry layout {rtype, addr, wdata}. Entry fields are sized to the
// widest supported address/data; narrower instances zero-extend into them.
package ace_pkg;

    localparam int ACE_ADDR_W = 32;
    localparam int ACE_DATA_W = 32;

    typedef enum logic [1:0] {
        REQ_READ    = 2'b00,
        REQ_WRITE   = 2'b01,
        REQ_INVALID = 2'b10,
        REQ_ILLEGAL = 2'b11
    } ace_req_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } seq_state_e;

    typedef struct packed {
        ace_req_e                rtype;
        logic [ACE_ADDR_W-1:0]   addr;
        logic [ACE_DATA_W-1:0]   wdata;
    } ace_req_t;

endpackage

// File: rtl/ace_req_fifo.sv
// rtl/ace_req_fifo.sv - synchronous request FIFO with combinational head
// Ports: clk, rst (async, active-high); push/din write an entry when not
// full; pop retires the head when not empty; head shows the oldest entry;
// full/empty/count report occupancy. A pop does not free space for a push
// in the same cycle when full, so full/empty come from the registered count.
module ace_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 66
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ace_req_sequencer.sv
// rtl/ace_req_sequencer.sv - buffers cache requests and issues them to ace_controller
// Ports: clk, rst (async, active-high).
//   Upstream: req_valid/req_ready/req_type/req_addr/req_wdata push requests;
//   done_valid/done_type/done_err report each completion (err = timed out);
//   illegal_err is sticky for accepted type-11 requests; busy, pending.
//   Controller: read_req/write_req/invalid_req one-cycle issue pulses with
//   issue_addr/issue_wdata held until the next issue; ace_ready completes;
//   ac_enable (snoop active) holds off new issue only.
module ace_req_sequencer
    import ace_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_type,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   read_req,
    output logic                   write_req,
    output logic                   invalid_req,
    output logic [ADDR_W-1:0]      issue_addr,
    output logic [DATA_W-1:0]      issue_wdata,
    input  logic                   ace_ready,
    input  logic                   ac_enable,
    output logic                   done_valid,
    output logic [1:0]             done_type,
    output logic                   done_err,
    output logic                   busy,
    output logic                   illegal_err,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_e state;
    seq_state_e state_nxt;
    ace_req_t   push_entry;
    ace_req_t   head_entry;
    ace_req_e   issue_type;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;
    logic       push_en;
    logic       pop_en;
    logic       latch_en;
    logic       done_set;
    logic       done_err_set;
    logic [TW-1:0] tmo_cnt;

    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    // Illegal requests are consumed at the interface and never queued.
    assign push_en   = accept && (req_type != REQ_ILLEGAL);
    assign busy      = (state != IDLE) || !fifo_empty;

    assign push_entry.rtype = ace_req_e'(req_type);
    assign push_entry.addr  = ACE_ADDR_W'(req_addr);
    assign push_entry.wdata = ACE_DATA_W'(req_wdata);

    ace_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ace_req_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .pop   (pop_en),
        .din   (push_entry),
        .head  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Pulses decode from registered state and type, so reset drops them at once.
    always_comb begin
        state_nxt    = state;
        read_req     = 1'b0;
        write_req    = 1'b0;
        invalid_req  = 1'b0;
        latch_en     = 1'b0;
        pop_en       = 1'b0;
        done_set     = 1'b0;
        done_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !ac_enable) begin
                    latch_en  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                read_req    = (issue_type == REQ_READ);
                write_req   = (issue_type == REQ_WRITE);
                invalid_req = (issue_type == REQ_INVALID);
                state_nxt   = WAIT;
            end
            WAIT: begin
                // Head stays queued until the transaction resolves either way.
                if (ace_ready) begin
                    pop_en    = 1'b1;
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    pop_en       = 1'b1;
                    done_set     = 1'b1;
                    done_err_set = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_type  <= REQ_READ;
            issue_addr  <= '0;
            issue_wdata <= '0;
        end else if (latch_en) begin
            issue_type  <= head_entry.rtype;
            issue_addr  <= head_entry.addr[ADDR_W-1:0];
            issue_wdata <= head_entry.wdata[DATA_W-1:0];
        end
    end

    // Cleared during ISSUE so it reads zero in the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT) && (tmo_cnt != TMO_LAST)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            done_type  <= 2'b00;
        end else begin
            done_valid <= done_set;
            done_err   <= done_err_set;
            if (done_set) done_type <= issue_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_err <= 1'b0;
        end else if (accept && (req_type == REQ_ILLEGAL)) begin
            illegal_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ace_req_sequencer.sv
// tb/tb_ace_req_sequencer.sv - scoreboard bench for ace_req_sequencer
module tb_ace_req_sequencer;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [1:0]             req_type = 2'b00;
    logic [ADDR_W-1:0]      req_addr = '0;
    logic [DATA_W-1:0]      req_wdata = '0;
    logic                   read_req;
    logic                   write_req;
    logic                   invalid_req;
    logic [ADDR_W-1:0]      issue_addr;
    logic [DATA_W-1:0]      issue_wdata;
    logic                   ace_ready = 1'b0;
    logic                   ac_enable = 1'b0;
    logic                   done_valid;
    logic [1:0]             done_type;
    logic                   done_err;
    logic                   busy;
    logic                   illegal_err;
    logic [$clog2(DEPTH):0] pending;

    ace_req_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
        .issue_addr(issue_addr), .issue_wdata(issue_wdata),
        .ace_ready(ace_ready), .ac_enable(ac_enable),
        .done_valid(done_valid), .done_type(done_type), .done_err(done_err),
        .busy(busy), .illegal_err(illegal_err), .pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] t; logic [31:0] a; logic [31:0] d; } iss_t;
    typedef struct { logic [1:0] t; logic err; int due; } dn_t;

    iss_t exp_issue[$];
    dn_t  exp_done[$];
    int   done_log[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   resp_mode = 0;      // 0 random latency, 1 never answer, 2 fixed_k
    int   fixed_k = 0;
    int   resp_at = -1;
    bit   mon_en = 1'b0;
    bit   force_ready = 1'b0;
    int   m_pending = 0;
    logic exp_illegal = 1'b0;
    int   last_issue_cyc = -1;
    int   push_cyc = 0;
    logic [31:0] cur_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input string act, input string exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=%s required=%s", name, act, exp);
    endtask

    // Monitor and responder: every issue pulse pops the oldest expected
    // request; the responder then chooses how many WAIT cycles pass before
    // ace_ready, which fixes whether and when the completion is due.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                int np;
                int k;
                iss_t e;
                dn_t dn;
                logic [1:0] gt;
                np = int'(read_req) + int'(write_req) + int'(invalid_req);
                if (np != 0) chk("issue_onehot", np, 1);
                if (np == 1) begin
                    gt = write_req ? 2'b01 : (invalid_req ? 2'b10 : 2'b00);
                    last_issue_cyc = cyc;
                    if (exp_issue.size() == 0) begin
                        bad("unexpected_issue", "pulse", "no pulse");
                    end else begin
                        e = exp_issue.pop_front();
                        chk("issue_type", gt, e.t);
                        chk("issue_addr", issue_addr, e.a);
                        if (e.t == 2'b01) chk("issue_wdata", issue_wdata, e.d);
                        cur_addr = e.a;
                        case (resp_mode)
                            0:       k = $urandom_range(0, TIMEOUT + 2);
                            1:       k = 1000;
                            default: k = fixed_k;
                        endcase
                        dn.t   = e.t;
                        dn.err = (k > TIMEOUT - 1);
                        dn.due = cyc + 2 + (dn.err ? TIMEOUT - 1 : k);
                        exp_done.push_back(dn);
                        resp_at = dn.err ? -1 : cyc + 1 + k;
                    end
                end
                if (done_valid) begin
                    done_log.push_back(cyc);
                    if (m_pending > 0) m_pending--;
                    if (exp_done.size() == 0) begin
                        bad("unexpected_done", "done_valid", "no done_valid");
                    end else begin
                        dn = exp_done.pop_front();
                        chk("done_type", done_type, dn.t);
                        chk("done_err", done_err, dn.err);
                        chk("done_cycle", cyc, dn.due);
                        chk("issue_addr_held", issue_addr, cur_addr);
                    end
                end
                chk("pending", pending, m_pending);
                chk("illegal_err", illegal_err, exp_illegal);
            end
            ace_ready = force_ready || (mon_en && (cyc == resp_at));
        end
    end

    task automatic push_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        int w = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            bad("push_accept", "req_ready low", "req_ready high");
            req_valid = 1'b0;
            return;
        end
        push_cyc = cyc + 1;
        if (t != 2'b11) exp_issue.push_back('{t, a, d});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (t != 2'b11) m_pending++;
        else            exp_illegal = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_issue.size() != 0 || exp_done.size() != 0 || busy) && n < 2000);
        if (n >= 2000) bad("wait_idle", "busy", "idle");
    endtask

    initial begin
        int base;
        int holds;
        int fall_cyc;
        logic [1:0] t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {read_req, write_req, invalid_req}, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_illegal_err", illegal_err, 0);
        chk("rst_issue_addr", issue_addr, 0);
        chk("rst_issue_wdata", issue_wdata, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single read, ace_ready four cycles after the pulse.
        resp_mode = 2;
        fixed_k = 3;
        push_req(2'b00, 32'h100, 32'hdead_beef);
        wait_idle();
        chk("t1_issue_latency", last_issue_cyc, push_cyc + 1);
        chk("t1_issue_addr", issue_addr, 32'h100);

        // Five writes, controller silent: fill, back-pressure, timeouts.
        resp_mode = 1;
        base = done_log.size();
        for (int i = 0; i < 4; i++) push_req(2'b01, 32'h2000 + i * 4, $urandom);
        @(negedge clk);
        chk("t2_req_ready_full", req_ready, 0);
        chk("t2_pending_full", pending, 4);
        push_req(2'b01, 32'h2010, $urandom);
        if (done_log.size() > base) chk("t2_fifth_held", push_cyc, done_log[base] + 1);
        else bad("t2_fifth_held", "accepted before completion", "after completion");
        wait_idle();

        // Snoop holds off an invalidate for ten cycles.
        resp_mode = 0;
        @(negedge clk);
        ac_enable = 1'b1;
        push_req(2'b10, 32'h3000, 32'h0);
        holds = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (invalid_req) holds++;
        end
        chk("t3_no_issue_in_snoop", holds, 0);
        chk("t3_busy_in_snoop", busy, 1);
        ac_enable = 1'b0;
        fall_cyc = cyc + 1;
        wait_idle();
        chk("t3_release_latency", last_issue_cyc, fall_cyc);

        // Timeout, then a stray ace_ready while idle must do nothing.
        resp_mode = 1;
        push_req(2'b00, 32'h4000, 32'h0);
        wait_idle();
        base = done_log.size();
        @(negedge clk);
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        force_ready = 1'b0;
        @(negedge clk);
        chk("t4_late_ready_ignored", done_log.size(), base);
        chk("t4_busy", busy, 0);

        // Illegal request is consumed, flagged and never queued.
        resp_mode = 0;
        chk("t5_illegal_before", illegal_err, 0);
        push_req(2'b11, 32'h5000, 32'h0);
        @(negedge clk);
        chk("t5_illegal_set", illegal_err, 1);
        chk("t5_pending_illegal", pending, 0);
        push_req(2'b00, 32'h5004, 32'h0);
        wait_idle();
        chk("t5_illegal_sticky", illegal_err, 1);

        // Random traffic with random snoop windows.
        resp_mode = 0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                ac_enable = ($urandom_range(0, 3) == 0);
            end
            ac_enable = 1'b0;
            t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            push_req(t, $urandom, $urandom);
        end
        ac_enable = 1'b0;
        wait_idle();

        // Reset during WAIT with three more queued.
        resp_mode = 1;
        for (int i = 0; i < 4; i++) push_req(2'b00, 32'h6000 + i * 4, 32'h0);
        @(negedge clk);
        chk("t7_pending_before", pending, 4);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t7_pulses", {read_req, write_req, invalid_req}, 0);
        chk("t7_pending", pending, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done_valid", done_valid, 0);
        holds = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_valid) holds++;
        end
        chk("t7_no_done_in_reset", holds, 0);
        exp_issue.delete();
        exp_done.delete();
        m_pending = 0;
        resp_at = -1;
        exp_illegal = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("t7_req_ready", req_ready, 1);
        repeat (6) @(negedge clk);
        chk("t7_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

endmodule
